// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver.
// Two-flop synchronizer on rx, start-bit validation at mid-bit, LSB-first
// data capture at mid-bit, stop-bit check and a one-cycle completion strobe.
// Optional even-parity checking is built when UART_RX_PARITY_EN is defined;
// that build adds the PARITY state and the parity_err port.
module uart_rx #(
  parameter int DBIT    = 8,   // data bits per frame, 5..8
  parameter int SB_TICK = 16   // ticks in stop state: 16/24/32 = 1/1.5/2 stop bits
) (
  input  logic            clk,
  input  logic            reset,         // synchronous, active-low
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;
`endif

  // synchronizer
  logic            r_sync1;
  logic            r_sync2;
  logic            w_rx_s;

  // FSM and datapath registers
  state_t          r_state;
  logic [4:0]      r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_ferr;

  // next-state values
  state_t          w_state;
  logic [4:0]      w_s;
  logic [NW-1:0]   w_n;
  logic [DBIT-1:0] w_b;
  logic [DBIT-1:0] w_dout;
  logic            w_done;
  logic            w_ferr;

`ifdef UART_RX_PARITY_EN
  logic            r_p;
  logic            r_perr;
  logic            w_p;
  logic            w_perr;
`endif

  assign w_rx_s = r_sync2;

  // Bring the asynchronous rx line into the clk domain; idles high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // State, counter, shift and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_p     <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_s     <= w_s;
      r_n     <= w_n;
      r_b     <= w_b;
      r_dout  <= w_dout;
      r_done  <= w_done;
      r_ferr  <= w_ferr;
`ifdef UART_RX_PARITY_EN
      r_p     <= w_p;
      r_perr  <= w_perr;
`endif
    end
  end

  // Next-state and datapath updates; everything holds unless a tick acts on it.
  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_n     = r_n;
    w_b     = r_b;
    w_dout  = r_dout;
    w_done  = 1'b0;
    w_ferr  = r_ferr;
`ifdef UART_RX_PARITY_EN
    w_p     = r_p;
    w_perr  = r_perr;
`endif

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_s     = '0;
          w_state = START;
        end
      end

      START: begin
        if (s_tick) begin
          if (r_s == 5'd7) begin
            if (!w_rx_s) begin
              // Middle of a valid start bit: counter now aligned to mid-bit.
              w_s     = '0;
              w_n     = '0;
              w_state = DATA;
            end else begin
              w_state = IDLE;
            end
          end else begin
            w_s = r_s + 5'd1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (r_s == 5'd15) begin
            w_s = '0;
            w_b = {w_rx_s, r_b[DBIT-1:1]};
            if (r_n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              w_state = PARITY;
`else
              w_state = STOP;
`endif
            end else begin
              w_n = r_n + NW'(1);
            end
          end else begin
            w_s = r_s + 5'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (r_s == 5'd15) begin
            w_s     = '0;
            w_p     = w_rx_s;
            w_state = STOP;
          end else begin
            w_s = r_s + 5'd1;
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (r_s == 5'(SB_TICK - 1)) begin
            w_state = IDLE;
            w_dout  = r_b;
            w_ferr  = ~w_rx_s;
            w_done  = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr  = (^r_b) ^ r_p;
`endif
          end else begin
            w_s = r_s + 5'd1;
          end
        end
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_perr;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART datapath. It consumes the 16× oversampling tick produced by the baud-rate counter, detects and validates the start bit, and samples each data bit at mid-bit. It shifts the data bits in LSB first, checks the stop bit, and presents the assembled word with a one-cycle completion strobe. The block sits between the external `rx` pin and the receive FIFO or interface logic.

## Interface
- `DBIT`, 8: data bits per frame; legal range 5–8.
- `SB_TICK`, 16: number of ticks spent in the stop state; 16, 24 or 32 for 1, 1.5 or 2 stop bits.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-low reset; `reset==0` at a rising `clk` edge resets the block.
- `rx`  input  1  asynchronous serial line; idles high.
- `s_tick`  input  1  one-`clk` pulse at 16× baud, from the baud-rate counter's max tick.
- `dout`  output  DBIT  last received word.
- `rx_done_tick`  output  1  one-`clk` pulse when a frame completes.
- `frame_err`  output  1  stop bit was sampled low in the last frame.
- `parity_err`  output  1  parity error in the last frame; present only with `UART_RX_PARITY_EN`.

## Operation
- `rx` passes through a 2-flop synchronizer, `rx_s`, before use. Both flops reset to 1. This adds 2 `clk` cycles of latency, and all sampling uses `rx_s`.
- Internal state:
  - FSM states: `IDLE`, `START`, `DATA`, `PARITY` (macro only), `STOP`.
  - 5-bit tick counter `s`.
  - Bit counter `n`, $clog_2(DBIT)$ bits wide.
  - Shift register `b`, DBIT bits wide.
- `IDLE`: when `rx_s==0`, clear `s` and go to `START`. `s_tick` is ignored in this state.
- `START`: on each `s_tick`:
  - If `s==7` and `rx_s==0`: clear `s` and `n`, go to `DATA`.
  - If `s==7` and `rx_s==1`: treat as a glitch and return to `IDLE` with no strobe.
  - Otherwise increment `s`.
- `DATA`: on each `s_tick` with `s==15`:
  - Clear `s` and load `b <= {rx_s, b[DBIT-1:1]}`, so the word is received LSB first.
  - If `n==DBIT-1`, go to `PARITY` (macro on) or to `STOP` (macro off).
  - Otherwise increment `n`.
  - On other ticks, increment `s`.
- `STOP`: on the `s_tick` with `s==SB_TICK-1`:
  - Go to `IDLE`.
  - Load `dout <= b` and `frame_err <= ~rx_s`.
  - Assert `rx_done_tick` on the next cycle.
  - On other ticks, increment `s`.
- `dout`, `frame_err` and `parity_err` are registered and hold their values until the next completion. They are not cleared when a new frame starts.
- Reset values: `dout=0`, `rx_done_tick=0`, `frame_err=0`, `parity_err=0`, state `IDLE`, `s=0`, `n=0`, `b=0`.
- Reset mid-frame aborts the frame immediately, with no strobe and no output update.
- If `rx_s` is low when the FSM enters `IDLE`, a new frame starts on the next cycle. Back-to-back frames need no idle gap.

## Timing
- `rx_done_tick` is high for exactly one `clk` cycle: the cycle after the edge that samples the final stop-state `s_tick`.
- `dout` and the error flags are valid in that same cycle.
- Start-bit to done latency is $(8 + 16 \cdot DBIT + SB_TICK)$ ticks, plus 16 more with parity, plus 2 `clk` for the synchronizer and 1 `clk` for the output register.
- Each data bit is sampled at tick 15 of its own bit period, which is mid-bit because the counter was aligned at the middle of the start bit.
- `s_tick` must be at most one cycle wide and must not occur on consecutive cycles. Its spacing is otherwise unconstrained.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the `PARITY` state and the `parity_err` port. Parity is even.
  - In `PARITY`, on the `s_tick` with `s==15`: clear `s`, latch `p <= rx_s`, go to `STOP`.
  - At completion, `parity_err <= ^b ^ p`.
  - A frame is 1 start bit, DBIT data bits, 1 parity bit and the stop bits.
- `UART_RX_PARITY_EN` undefined:
  - No `PARITY` state and no `parity_err` port.
  - `DATA` goes directly to `STOP`.

## Test plan
- 8N1 frame carrying 0xA5, `s_tick` every 4 `clk` → one `rx_done_tick` pulse, `dout=0xA5`, `frame_err=0`.
- Frame 0x3C with the stop bit driven low → `rx_done_tick` pulses, `dout=0x3C`, `frame_err=1`.
- `rx` low for only 4 ticks, then high → FSM returns to `IDLE`, no `rx_done_tick`, `dout` unchanged.
- `reset=0` for one cycle during data bit 3 of a frame, then a clean 0x5A frame → outputs read 0 after reset, then `dout=0x5A` with a single pulse.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two pulses, `dout=0x00` then `0xFF`, `frame_err=0` on both.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 → `parity_err=1`; with parity bit 1 → `parity_err=0`.
